// File: rtl/debounce_sync_if.sv
// Signal bundle between the raw-input side and the debounced-level consumer.
// The master drives the raw input and clear; the slave (debouncer) returns level and status.
interface debounce_sync_if #(
  parameter int BCNT_W = 8
);
  logic              a_i;
  logic              clr_i;
  logic              level_o;
  logic              busy_o;
  logic [BCNT_W-1:0] bounce_cnt_o;

  modport master (
    output a_i,
    output clr_i,
    input  level_o,
    input  busy_o,
    input  bounce_cnt_o
  );

  modport slave (
    input  a_i,
    input  clr_i,
    output level_o,
    output busy_o,
    output bounce_cnt_o
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous input and only lets the output level follow it
// after DEBOUNCE_CYCLES consecutive differing samples; aborted attempts are counted.
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0,
  parameter int   BCNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  debounce_sync_if.slave   bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX  = '1;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   r_level;
  logic                   w_levelNext;
  logic                   w_bounce;
  logic [BCNT_W-1:0]      r_bounceCnt;

  // Raw input touches nothing but the first synchronizer flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.a_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_level <= RESET_VAL;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_level <= w_levelNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_levelNext = r_level;
    w_bounce    = 1'b0;
    case (r_state)
      STABLE: begin
        w_cntNext = '0;
        if (w_s != r_level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_levelNext = w_s;
          end else begin
            w_stateNext = CHECK;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      CHECK: begin
        if (w_s != r_level) begin
          if (r_cnt == CNT_LAST) begin
            w_levelNext = w_s;
            w_stateNext = STABLE;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end else begin
          // Sample fell back to the current level before qualifying: a bounce.
          w_stateNext = STABLE;
          w_cntNext   = '0;
          w_bounce    = 1'b1;
        end
      end
    endcase
  end

  // Clear takes priority over a coincident bounce; the count never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bounceCnt <= '0;
    end else if (bus.clr_i) begin
      r_bounceCnt <= '0;
    end else if (w_bounce && (r_bounceCnt != BCNT_MAX)) begin
      r_bounceCnt <= r_bounceCnt + 1'b1;
    end
  end

  assign bus.level_o      = r_level;
  assign bus.busy_o       = (r_state == CHECK);
  assign bus.bounce_cnt_o = r_bounceCnt;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance, a 2-bit bounce counter
// instance and a single-cycle debounce instance, all with hand-computed edge timing.
module tb_debounce_sync;

  logic clk;
  logic reset_n;
  int   checkCount;
  int   errorCount;
  int   busySeen;

  debounce_sync_if #(.BCNT_W(8)) ifA ();
  debounce_sync_if #(.BCNT_W(2)) ifB ();
  debounce_sync_if #(.BCNT_W(8)) ifC ();

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_VAL(1'b0), .BCNT_W(8)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(ifA.slave)
  );
  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_VAL(1'b0), .BCNT_W(2)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(ifB.slave)
  );
  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0), .BCNT_W(8)) dutC (
    .clk(clk), .reset_n(reset_n), .bus(ifC.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic aVal, input int cycles);
    ifA.a_i = aVal;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset_n    = 1'b0;
    ifA.a_i = 1'b1; ifA.clr_i = 1'b0;
    ifB.a_i = 1'b0; ifB.clr_i = 1'b0;
    ifC.a_i = 1'b0; ifC.clr_i = 1'b0;

    // Reset with input already high, then release: acts as a clean 0->1 step.
    tick(3);
    checkOutput("rst_level", 32'(ifA.level_o), 0);
    checkOutput("rst_busy", 32'(ifA.busy_o), 0);
    checkOutput("rst_bcnt", 32'(ifA.bounce_cnt_o), 0);
    reset_n = 1'b1;
    tick(2);
    checkOutput("rise_busy_e2", 32'(ifA.busy_o), 0);
    tick(1);
    checkOutput("rise_busy_e3", 32'(ifA.busy_o), 1);
    tick(14);
    checkOutput("rise_busy_e17", 32'(ifA.busy_o), 1);
    checkOutput("rise_level_e17", 32'(ifA.level_o), 0);
    tick(1);
    checkOutput("rise_level_e18", 32'(ifA.level_o), 1);
    checkOutput("rise_busy_e18", 32'(ifA.busy_o), 0);
    checkOutput("rise_bcnt", 32'(ifA.bounce_cnt_o), 0);

    // Clean 1->0 step.
    applyStimulus(1'b0, 17);
    checkOutput("fall_level_e17", 32'(ifA.level_o), 1);
    tick(1);
    checkOutput("fall_level_e18", 32'(ifA.level_o), 0);

    // Asynchronous reset while the qualification counter sits at 10.
    applyStimulus(1'b1, 12);
    checkOutput("midchk_busy_pre", 32'(ifA.busy_o), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midchk_busy_async", 32'(ifA.busy_o), 0);
    checkOutput("midchk_level_async", 32'(ifA.level_o), 0);
    checkOutput("midchk_bcnt_async", 32'(ifA.bounce_cnt_o), 0);
    tick(2);
    reset_n = 1'b1;
    tick(17);
    checkOutput("midchk_relaunch_e17", 32'(ifA.level_o), 0);
    tick(1);
    checkOutput("midchk_relaunch_e18", 32'(ifA.level_o), 1);
    checkOutput("midchk_bcnt_after", 32'(ifA.bounce_cnt_o), 0);
    applyStimulus(1'b0, 18);
    checkOutput("midchk_back_low", 32'(ifA.level_o), 0);

    // Five-clock glitch: busy for five cycles, one bounce, level untouched.
    busySeen = 0;
    ifA.a_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 5) ifA.a_i = 1'b0;
      busySeen += int'(ifA.busy_o);
    end
    checkOutput("glitch_busy_cycles", 32'(busySeen), 5);
    checkOutput("glitch_level", 32'(ifA.level_o), 0);
    checkOutput("glitch_bcnt", 32'(ifA.bounce_cnt_o), 1);

    // Bounce train of 3/7/2 clock intervals, then a held high.
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 7);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 7);
    checkOutput("train_bcnt", 32'(ifA.bounce_cnt_o), 3);
    checkOutput("train_level_pre", 32'(ifA.level_o), 0);
    applyStimulus(1'b1, 17);
    checkOutput("train_level_e17", 32'(ifA.level_o), 0);
    tick(1);
    checkOutput("train_level_e18", 32'(ifA.level_o), 1);
    checkOutput("train_bcnt_final", 32'(ifA.bounce_cnt_o), 3);

    // Narrow bounce counter saturates at 3.
    for (int g = 1; g <= 5; g++) begin
      ifB.a_i = 1'b1;
      tick(4);
      ifB.a_i = 1'b0;
      tick(6);
      checkOutput($sformatf("sat_bcnt_g%0d", g), 32'(ifB.bounce_cnt_o), (g < 3) ? 32'(g) : 32'd3);
    end
    checkOutput("sat_level", 32'(ifB.level_o), 0);

    // Clear on the very edge the bounce is detected.
    ifB.a_i = 1'b1;
    tick(4);
    ifB.a_i = 1'b0;
    tick(2);
    checkOutput("clr_busy_pre", 32'(ifB.busy_o), 1);
    ifB.clr_i = 1'b1;
    tick(1);
    ifB.clr_i = 1'b0;
    checkOutput("clr_busy_post", 32'(ifB.busy_o), 0);
    checkOutput("clr_wins_bcnt", 32'(ifB.bounce_cnt_o), 0);
    ifB.a_i = 1'b1;
    tick(4);
    ifB.a_i = 1'b0;
    tick(6);
    checkOutput("clr_resume_bcnt", 32'(ifB.bounce_cnt_o), 1);

    // Single-cycle debounce: level follows at edge 3, never busy.
    busySeen = 0;
    ifC.a_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      busySeen += int'(ifC.busy_o);
      if (i == 2) checkOutput("min_level_e2", 32'(ifC.level_o), 0);
      if (i == 3) checkOutput("min_level_e3", 32'(ifC.level_o), 1);
    end
    checkOutput("min_busy_never", 32'(busySeen), 0);
    checkOutput("min_bcnt", 32'(ifC.bounce_cnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, possibly bouncing input (pushbutton, external strobe) into a clean, clock-synchronous level.
- Sits directly upstream of the rise/fall edge detector: `level_o` drives that stage's `a_i`.
- Provides a multi-flop synchronizer and a counter-based debounce state machine.
- Adds status outputs: check-in-progress and a count of rejected bounces.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples that must differ from `level_o` before `level_o` flips; legal range >= 1.
- RESET_VAL, 0, reset value of synchronizer flops and `level_o`.
- BCNT_W, 8, width of bounce counter.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- a_i  input  1  raw asynchronous input.
- clr_i  input  1  synchronous clear of `bounce_cnt_o`.
- level_o  output  1  debounced, synchronized level.
- busy_o  output  1  high while a candidate change is being qualified.
- bounce_cnt_o  output  BCNT_W  saturating count of aborted qualifications.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (port `reset_n`). Reset asserts immediately, independent of `clk`. Release is sampled on posedge.
- Reset values:
  - Synchronizer flops = RESET_VAL.
  - `level_o` = RESET_VAL.
  - State = STABLE.
  - Internal counter `cnt` = 0.
  - `busy_o` = 0.
  - `bounce_cnt_o` = 0.
- Synchronizer: `a_i` passes through a SYNC_STAGES flop chain. Let `s` be the last stage. Only `s` is used downstream; `a_i` must never reach any other logic.
- State STABLE (`busy_o` = 0):
  - `s` == `level_o`: remain; `cnt` = 0.
  - `s` != `level_o` and DEBOUNCE_CYCLES == 1: flip `level_o` this edge; stay STABLE.
  - `s` != `level_o` otherwise: go to CHECK; `cnt` <= 1.
- State CHECK (`busy_o` = 1):
  - `s` != `level_o` and `cnt` == DEBOUNCE_CYCLES-1: flip `level_o`; go to STABLE; `cnt` <= 0.
  - `s` != `level_o` otherwise: `cnt` <= `cnt`+1.
  - `s` == `level_o` (bounce): go to STABLE; `cnt` <= 0; `bounce_cnt_o` increments.
- Counter width: `cnt` is $clog2(DEBOUNCE_CYCLES+1) bits.
- Latency: if `a_i` changes once and stays stable, `level_o` changes at posedge number SYNC_STAGES+DEBOUNCE_CYCLES after the first edge that samples the new value. With defaults, that is edge 18.
- `level_o` is registered, with no combinational path from `a_i` and at most one toggle per clock.
- `bounce_cnt_o`:
  - Saturates at 2^BCNT_W-1 and does not wrap.
  - `clr_i` forces 0 on the next edge.
  - If `clr_i` and a bounce occur on the same edge, clear wins and the result is 0.
- Reset asserted mid-CHECK: all state returns to reset values immediately. The partial qualification is discarded and is not counted as a bounce.
- A pulse on `a_i` shorter than one clock may be missed entirely; this is acceptable behaviour.

Test Plan:
- Reset and idle: hold `reset_n`=0 with `a_i`=1, then release.
  - Required: `level_o`=0, `busy_o`=0, `bounce_cnt_o`=0.
  - Required: `level_o` rises at edge 18 after release, because the sync chain resets to RESET_VAL.
- Clean step: with defaults, `a_i` 0->1 and hold.
  - Required: `busy_o` high from edge 3 to edge 17.
  - Required: `level_o`=1 from edge 18.
  - Required: `bounce_cnt_o` stays 0.
  - Then `a_i` 1->0 and hold: required `level_o`=0 exactly 18 edges later.
- Glitch rejection: `a_i`=1 for 5 clocks, then back to 0.
  - Required: `level_o` stays 0; `busy_o` pulses for 5 cycles; `bounce_cnt_o`=1.
- Bounce train: toggles at 3, 7 and 2 clock intervals, then stays 1.
  - Required: `bounce_cnt_o`=3.
  - Required: `level_o`=1 exactly 18 edges after the final transition.
- Reset mid-CHECK: assert `reset_n`=0 asynchronously while `cnt`=10.
  - Required: `busy_o` and `cnt` clear without waiting for a clock edge; `bounce_cnt_o` stays unchanged at 0.
- Saturation, clear and minimum debounce (BCNT_W=2): 5 glitches.
  - Required: `bounce_cnt_o`=3.
  - `clr_i` asserted on the same edge as a bounce: required 0 after that edge.
  - With DEBOUNCE_CYCLES=1, a step on `a_i`: required `level_o` flips at edge 3 and `busy_o` never asserts.
